// File: rtl/receiver_uart.sv
// UART receiver: 16x oversampled, 8 data bits LSB-first, even parity, one stop bit.
// Includes the baud_controller that produces the oversampling tick.

module baud_controller (
    input  logic       reset,
    input  logic       clk,
    input  logic [2:0] baud_select,
    output logic       sample_enable_o
);
    logic [13:0] limit;
    logic [13:0] cnt_q, cnt_d;

    always_comb begin
        limit = 14'd27;
        case (baud_select)
            3'b000: limit = 14'd10417;
            3'b001: limit = 14'd2604;
            3'b010: limit = 14'd651;
            3'b011: limit = 14'd326;
            3'b100: limit = 14'd163;
            3'b101: limit = 14'd81;
            3'b110: limit = 14'd54;
            default: limit = 14'd27;
        endcase
    end

    // ">=" lets a mid-count switch to a faster rate wrap immediately instead of overrunning.
    assign sample_enable_o = (cnt_q >= limit - 14'd1);
    assign cnt_d = sample_enable_o ? 14'd0 : cnt_q + 14'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

module receiver_uart #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       RX_EN,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR,
    output logic       Rx_VALID,
    output logic       RX_BUSY
);
    typedef enum logic [2:0] {IDLE, RSTART, RDATA, RPARITY, RSTOP} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs, tick, maj;
    logic [3:0]             cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shreg_q, shreg_d;
    logic                   s7_q, s7_d, s8_q, s8_d;
    logic                   par_q, par_d;
    logic [7:0]             data_q, data_d;
    logic                   perr_q, perr_d, ferr_q, ferr_d, valid_q, valid_d;

    baud_controller u_baud (
        .reset          (reset),
        .clk            (clk),
        .baud_select    (baud_select),
        .sample_enable_o(tick)
    );

    assign rxs = sync_q[SYNC_STAGES-1];
    assign maj = (s7_q & s8_q) | (s7_q & rxs) | (s8_q & rxs);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        s7_d    = s7_q;
        s8_d    = s8_q;
        par_d   = par_q;
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        valid_d = 1'b0;
        if (!RX_EN) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else if (tick) begin
            if (state_q == IDLE) begin
                if (!rxs) begin
                    state_d = RSTART;
                    cnt_d   = 4'd0;
                    bit_d   = 3'd0;
                end
            end else begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd7) s7_d = rxs;
                if (cnt_q == 4'd8) s8_d = rxs;
                case (state_q)
                    RSTART: begin
                        if (cnt_q == 4'd9 && maj) begin
                            state_d = IDLE;
                            cnt_d   = 4'd0;
                        end else if (cnt_q == 4'd15) begin
                            state_d = RDATA;
                        end
                    end
                    RDATA: begin
                        if (cnt_q == 4'd9) shreg_d = {maj, shreg_q[7:1]};
                        if (cnt_q == 4'd15) begin
                            bit_d = bit_q + 3'd1;
                            if (bit_q == 3'd7) state_d = RPARITY;
                        end
                    end
                    RPARITY: begin
                        if (cnt_q == 4'd9) par_d = maj;
                        if (cnt_q == 4'd15) state_d = RSTOP;
                    end
                    RSTOP: begin
                        // Leave at mid-stop so a start bit right after the stop is caught.
                        if (cnt_q == 4'd9) begin
                            data_d  = shreg_q;
                            perr_d  = (par_q != ^shreg_q);
                            ferr_d  = ~maj;
                            valid_d = 1'b1;
                            state_d = IDLE;
                            cnt_d   = 4'd0;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sync_q  <= '1;
            cnt_q   <= 4'd0;
            bit_q   <= 3'd0;
            shreg_q <= 8'h00;
            s7_q    <= 1'b1;
            s8_q    <= 1'b1;
            par_q   <= 1'b0;
            data_q  <= 8'h00;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], RxD};
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            s7_q    <= s7_d;
            s8_q    <= s8_d;
            par_q   <= par_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            valid_q <= valid_d;
        end
    end

    assign Rx_DATA   = data_q;
    assign Rx_PERROR = perr_q;
    assign Rx_FERROR = ferr_q;
    assign Rx_VALID  = valid_q;
    assign RX_BUSY   = (state_q != IDLE);
endmodule

// File: tb/tb_receiver_uart.sv
// Bench for receiver_uart at 115200 baud: directed frames, aborts, glitch and random frames
// checked against an expected-record queue built from the frame-format rules.

module tb_receiver_uart;
    localparam int TICK_CLK = 27;
    localparam int BIT_CLK  = 16 * TICK_CLK;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] baud_select;
    logic       RX_EN;
    logic       RxD;
    logic [7:0] Rx_DATA;
    logic       Rx_PERROR, Rx_FERROR, Rx_VALID, RX_BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected record: {data, perror, ferror}
    logic [9:0] exp_q[$];
    logic [7:0] last_data;
    logic       last_perr, last_ferr;
    logic       prev_valid = 1'b0;

    receiver_uart #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .baud_select(baud_select),
        .RX_EN      (RX_EN),
        .RxD        (RxD),
        .Rx_DATA    (Rx_DATA),
        .Rx_PERROR  (Rx_PERROR),
        .Rx_FERROR  (Rx_FERROR),
        .Rx_VALID   (Rx_VALID),
        .RX_BUSY    (RX_BUSY)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every VALID pulse must match the oldest expected record.
    always @(negedge clk) begin
        if (Rx_VALID) begin
            check("valid_width", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'd1, 32'd0);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                check("rx_data", {24'd0, Rx_DATA}, {24'd0, e[9:2]});
                check("rx_perror", {31'd0, Rx_PERROR}, {31'd0, e[1]});
                check("rx_ferror", {31'd0, Rx_FERROR}, {31'd0, e[0]});
            end
        end
        prev_valid <= Rx_VALID;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            RxD = frame[i];
            wait_clk(BIT_CLK);
        end
    endtask

    task automatic check_held(input string tag);
        check({tag, "_data"}, {24'd0, Rx_DATA}, {24'd0, last_data});
        check({tag, "_perr"}, {31'd0, Rx_PERROR}, {31'd0, last_perr});
        check({tag, "_ferr"}, {31'd0, Rx_FERROR}, {31'd0, last_ferr});
    endtask

    // Parity bit sent is the even parity of d, inverted when bad_par is set.
    task automatic send_byte(input logic [7:0] d, input logic bad_par, input logic stop_bit,
                             input int gap_bits);
        logic par;
        logic exp_perr;
        par      = (^d) ^ bad_par;
        exp_perr = (par != (^d));
        exp_q.push_back({d, exp_perr, ~stop_bit});
        last_data = d;
        last_perr = exp_perr;
        last_ferr = ~stop_bit;
        drive_bits({stop_bit, par, d, 1'b0}, 11);
        RxD = 1'b1;
        check("frame_received", exp_q.size(), 32'd0);
        wait_clk(gap_bits * BIT_CLK);
    endtask

    initial begin
        logic busy_seen;
        reset       = 1'b1;
        baud_select = 3'b111;
        RX_EN       = 1'b1;
        RxD         = 1'b1;
        last_data   = 8'h00;
        last_perr   = 1'b0;
        last_ferr   = 1'b0;
        wait_clk(5);
        check("reset_busy", {31'd0, RX_BUSY}, 32'd0);
        check("reset_valid", {31'd0, Rx_VALID}, 32'd0);
        check_held("reset");
        reset = 1'b0;
        wait_clk(BIT_CLK);

        send_byte(8'hA5, 1'b0, 1'b1, 1);
        send_byte(8'h3C, 1'b1, 1'b1, 1);
        send_byte(8'h81, 1'b0, 1'b0, 2);
        send_byte(8'h55, 1'b0, 1'b1, 1);

        // Short low glitch in idle: busy briefly, no frame.
        busy_seen = 1'b0;
        RxD = 1'b0;
        for (int i = 0; i < 5 * TICK_CLK; i++) begin
            wait_clk(1);
            if (RX_BUSY) busy_seen = 1'b1;
        end
        RxD = 1'b1;
        for (int i = 0; i < 20 * TICK_CLK; i++) begin
            wait_clk(1);
            if (RX_BUSY) busy_seen = 1'b1;
        end
        check("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
        check("glitch_busy_low", {31'd0, RX_BUSY}, 32'd0);
        check_held("glitch");

        send_byte(8'h00, 1'b0, 1'b1, 0);
        send_byte(8'hFF, 1'b0, 1'b1, 1);

        // RX_EN dropped in the middle of data bit 3.
        drive_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 4);
        RxD = 1'b0;
        wait_clk(BIT_CLK / 2);
        RX_EN = 1'b0;
        RxD   = 1'b1;
        wait_clk(2);
        check("en_abort_idle", {31'd0, RX_BUSY}, 32'd0);
        wait_clk(3 * BIT_CLK);
        check_held("en_abort");
        RX_EN = 1'b1;
        wait_clk(BIT_CLK);
        send_byte(8'h12, 1'b0, 1'b1, 1);

        // Reset in the middle of data bit 3.
        drive_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 4);
        RxD = 1'b0;
        wait_clk(BIT_CLK / 2);
        reset = 1'b1;
        RxD   = 1'b1;
        wait_clk(5);
        reset = 1'b0;
        last_data = 8'h00;
        last_perr = 1'b0;
        last_ferr = 1'b0;
        wait_clk(2 * BIT_CLK);
        check("rst_abort_idle", {31'd0, RX_BUSY}, 32'd0);
        check_held("rst_abort");
        send_byte(8'h12, 1'b0, 1'b1, 1);

        for (int k = 0; k < 3; k++) begin
            logic [7:0] d;
            logic       bp, sb;
            d  = 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 3) != 0);
            send_byte(d, bp, sb, sb ? int'($urandom_range(0, 1)) : 2);
        end

        wait_clk(2 * BIT_CLK);
        check("final_drained", exp_q.size(), 32'd0);
        check("final_busy", {31'd0, RX_BUSY}, 32'd0);
        check_held("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
